uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It detects each completed frame from the receiver's `P_DATA`/`data_valid`/`par_err`/`stp_err` outputs and stores it, with its error tags, in a first-word-fall-through FIFO. The FIFO drains through a valid/ready read port toward the host or register interface. Overflow is flagged sticky, and error frames can optionally be dropped and counted instead of stored.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2..64.
- `DROP_ERR`, 0: when 1, error frames are counted and discarded instead of stored.
- `clk` input 1: single clock, shared with the receiver.
- `rst` input 1: synchronous, active-high reset.
- `P_DATA` input 8: received byte from the receiver.
- `data_valid` input 1: receiver frame-good indication.
- `par_err` input 1: receiver parity-error indication.
- `stp_err` input 1: receiver stop-error indication.
- `rd_data` output 8: head-entry byte.
- `rd_par_err` output 1: head-entry parity-error tag.
- `rd_stp_err` output 1: head-entry stop-error tag.
- `rd_valid` output 1: the FIFO is non-empty.
- `rd_ready` input 1: consumer accepts the head entry.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `overflow` output 1: sticky; set when a frame was lost because the FIFO was full.
- `ovf_clr` input 1: single-cycle clear of `overflow`.
- `err_drop_cnt` output 8: number of error frames dropped (`DROP_ERR=1`); saturates at 255.

## Operation
- **Frame event.** A frame event is a rising edge of `data_valid`, `par_err` or `stp_err`, detected against 1-cycle-delayed copies held in internal registers.
  - Simultaneous rising edges in one cycle produce exactly one event.
  - A level held high does not produce repeated events.
- **Event capture.** The stored entry is {`P_DATA`, `par_err`, `stp_err`} sampled in the event cycle.
- **Error frames.** An entry is an error frame if `par_err` or `stp_err` is high in the event cycle.
  - With `DROP_ERR=1`, an error frame is not written; `err_drop_cnt` increments (saturating at 255).
  - With `DROP_ERR=0`, `err_drop_cnt` stays 0.
- **Push.**
  - A push is accepted when `!full`, or when `full` and a pop happens in the same cycle.
  - Otherwise the frame is discarded and `overflow` sets.
- **Pop.** A pop occurs when `rd_valid && rd_ready`. The read pointer advances and `count` decrements.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
- **Read port (FWFT).** `rd_data`/`rd_*_err` always show the entry at the read pointer.
  - These outputs are don't-care while `empty`; the bench must not check them then.
  - They hold stable while `rd_valid && !rd_ready`.
- **Pointers.** Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- **Overflow flag.** If `ovf_clr` and a new overflow coincide, set wins.
- **Reset state.** In any cycle with `rst` high, every register is cleared, including a push or pop in progress. After reset:
  - Pointers, `count` and `err_drop_cnt` are 0.
  - `empty`=1, `full`=0, `rd_valid`=0, `overflow`=0.
  - `rd_data` and the error tags read 0.
  - Edge-detect registers are cleared, so an input already high when reset releases counts as a rising edge.

## Timing
- **Write latency.** An event in cycle N is written at the clock edge ending cycle N. `rd_valid`, `count`, `empty` and `full` reflect it in cycle N+1.
- **Pop latency.** A pop in cycle N presents the next entry in cycle N+1.
- **No combinational paths:**
  - No combinational path from the receiver inputs to any output.
  - `rd_valid` does not depend on `rd_ready`.
- **Throughput.** One push and one pop per cycle, sustained.

## Structure
- **Shared package `uart_rx_pkg`:**
  - An `rx_entry_t` struct {data[7:0], par_err, stp_err}.
  - Constant `RX_ENTRY_W = 10`.
- **Sub-module `uart_rx_fifo_mem`:**
  - DEPTH×`RX_ENTRY_W` register array.
  - Synchronous write port, asynchronous read port.
  - No reset on the array.
- **Top level.** Holds edge detection, pointers, counters and flags.

## Test plan
- **Reset and single frame.** Reset, then pulse `data_valid` for 1 cycle with `P_DATA`=0xA5.
  - Next cycle: `rd_valid`=1, `rd_data`=0xA5, tags 0, `count`=1.
  - Pop: `empty`=1.
- **Fill and overflow.** DEPTH=8: push 9 frames 0x00..0x08 with no pops.
  - After 8 frames: `full`=1.
  - 9th frame: `overflow`=1.
  - Drain order is 0x00..0x07.
  - `ovf_clr` clears `overflow`.
- **Push and pop while full.** With the FIFO full, push and pop in the same cycle.
  - No overflow; `count` stays 8.
  - Popped value is the old head; the new byte becomes the last entry.
- **Error frame stored.** `DROP_ERR=0`: rising `stp_err` with `P_DATA`=0x3C → stored entry 0x3C, `rd_stp_err`=1, `rd_par_err`=0.
- **Error frame dropped.** `DROP_ERR=1`: 3 parity-error frames, then a good frame 0x11.
  - `err_drop_cnt`=3, `count`=1, head 0x11.
  - `data_valid` held high 5 cycles → one entry only.
- **Wrap and reset mid-stream.**
  - Wrap: 20 interleaved push/pop operations with random `rd_ready` → all entries come out in order across pointer wrap.
  - Reset: assert `rst` with 4 entries stored → next cycle `count`=0, `empty`=1, `overflow`=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive buffer: the stored frame entry
// and its packed width.
package uart_rx_pkg;

    localparam int RX_ENTRY_W = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       par_err;
        logic       stp_err;
    } rx_entry_t;

    function automatic logic entry_is_err(input rx_entry_t e);
        return e.par_err | e.stp_err;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage for the receive FIFO: synchronous write, asynchronous
// read, no reset on the array.
module uart_rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  rx_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output rx_entry_t       rdata_o
);

    rx_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer: detects completed UART frames, stores
// them with their error tags and drains through a valid/ready port.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter bit DROP_ERR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             P_DATA,
    input  logic                   data_valid,
    input  logic                   par_err,
    input  logic                   stp_err,
    output logic [7:0]             rd_data,
    output logic                   rd_par_err,
    output logic                   rd_stp_err,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [7:0]             err_drop_cnt
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          dv_q, pe_q, se_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    logic      frame_ev;
    logic      frame_err;
    logic      want_wr;
    logic      push;
    logic      pop;
    logic      is_full;
    logic      is_empty;
    rx_entry_t wr_entry;
    rx_entry_t rd_entry;

    // Several inputs rising together still describe one frame.
    always_comb begin
        wr_entry  = '{data: P_DATA, par_err: par_err, stp_err: stp_err};
        frame_ev  = (data_valid & ~dv_q)
                  | (par_err & ~pe_q)
                  | (stp_err & ~se_q);
        frame_err = entry_is_err(wr_entry);
        want_wr   = frame_ev & ~(DROP_ERR & frame_err);
    end

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign pop      = ~is_empty & rd_ready;
    assign push     = want_wr & (~is_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A frame lost this cycle outranks a clear request.
        if (want_wr && is_full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (DROP_ERR && frame_ev && frame_err && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            dv_q     <= data_valid;
            pe_q     <= par_err;
            se_q     <= stp_err;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // The array is never reset, so mask the head while nothing is stored.
    assign rd_data      = is_empty ? 8'h00 : rd_entry.data;
    assign rd_par_err   = is_empty ? 1'b0  : rd_entry.par_err;
    assign rd_stp_err   = is_empty ? 1'b0  : rd_entry.stp_err;
    assign rd_valid     = ~is_empty;
    assign count        = count_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign overflow     = ovf_q;
    assign err_drop_cnt = drop_q;

endmodule
